// File: rtl/gate_lut_pkg.sv
// gate_lut_pkg: shared types and named truth-table codes for gate_lut_unit.
// Codes index bits by {a,b}: bit0 = f(0,0), bit3 = f(1,1).
package gate_lut_pkg;

  typedef logic [3:0] tt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_DONE
  } sweep_st_e;

  localparam tt_t TT_AND     = 4'b1000;
  localparam tt_t TT_OR      = 4'b1110;
  localparam tt_t TT_XOR     = 4'b0110;
  localparam tt_t TT_NAND    = 4'b0111;
  localparam tt_t TT_OR_NOTB = 4'b1101;

endpackage

// File: rtl/gate_lut_if.sv
// gate_lut_if: operand/result valid-ready bundle for gate_lut_unit.
// master = producer/consumer side, slave = the unit.
interface gate_lut_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_s
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_s
  );
endinterface

// File: rtl/gate_lut_eval.sv
// gate_lut_eval: combinational bitwise two-input LUT.
// Each result bit is tt indexed by {a[i], b[i]}.
module gate_lut_eval
  import gate_lut_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  tt_t              tt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);

  always_comb begin
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = tt[{a[i], b[i]}];
    end
  end

endmodule

// File: rtl/gate_lut_unit.sv
// gate_lut_unit: registered 16-function bitwise logic stage, valid/ready.
// Optional truth-table self-check sweep under GATE_LUT_SWEEP_EN.
module gate_lut_unit
  import gate_lut_pkg::*;
#(
  parameter int  WIDTH    = 8,
  parameter tt_t TT_RESET = TT_OR_NOTB
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  tt_t        cfg_tt,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output tt_t        sweep_tt,
  output logic       match,
  gate_lut_if.slave  bus
);

  tt_t              tt_q, tt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_s_q, out_s_d;
  logic [WIDTH-1:0] eval_a, eval_b, eval_s;
  logic             xfer;

  gate_lut_eval #(.WIDTH(WIDTH)) u_eval (
    .tt (tt_q),
    .a  (eval_a),
    .b  (eval_b),
    .s  (eval_s)
  );

`ifdef GATE_LUT_SWEEP_EN
  sweep_st_e st_q, st_d;
  tt_t       sw_tt_q, sw_tt_d;
  logic      match_q, match_d;
  logic      agree_q, agree_d;
  logic      sweeping;
  logic [1:0] sw_idx;

  always_comb begin
    sweeping = 1'b1;
    sw_idx   = 2'd0;
    unique case (st_q)
      ST_S0:   sw_idx = 2'd0;
      ST_S1:   sw_idx = 2'd1;
      ST_S2:   sw_idx = 2'd2;
      ST_S3:   sw_idx = 2'd3;
      default: sweeping = 1'b0;
    endcase
  end

  // Sweep owns the evaluator; datapath is blocked by in_ready meanwhile
  assign eval_a = sweeping ? {WIDTH{sw_idx[1]}} : bus.in_a;
  assign eval_b = sweeping ? {WIDTH{sw_idx[0]}} : bus.in_b;

  always_comb begin
    st_d    = st_q;
    sw_tt_d = sw_tt_q;
    match_d = match_q;
    agree_d = agree_q;
    unique case (st_q)
      ST_IDLE: if (start) begin
        st_d    = ST_S0;
        sw_tt_d = '0;
        match_d = 1'b0;
        agree_d = 1'b1;
      end
      ST_S0:   st_d = ST_S1;
      ST_S1:   st_d = ST_S2;
      ST_S2:   st_d = ST_S3;
      ST_S3:   st_d = ST_DONE;
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    if (sweeping) begin
      sw_tt_d[sw_idx] = eval_s[0];
      if (eval_s != {WIDTH{eval_s[0]}}) agree_d = 1'b0;
    end
    if (st_q == ST_S3) match_d = agree_d && (sw_tt_d == tt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      sw_tt_q <= '0;
      match_q <= 1'b0;
      agree_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      sw_tt_q <= sw_tt_d;
      match_q <= match_d;
      agree_q <= agree_d;
    end
  end

  assign busy     = sweeping;
  assign done     = (st_q == ST_DONE);
  assign sweep_tt = sw_tt_q;
  assign match    = match_q;
`else
  logic unused_start;

  assign unused_start = start;
  assign eval_a       = bus.in_a;
  assign eval_b       = bus.in_b;
  assign busy         = 1'b0;
  assign done         = 1'b0;
  assign sweep_tt     = '0;
  assign match        = 1'b0;
`endif

  assign bus.in_ready  = (!out_valid_q || bus.out_ready) && !busy;
  assign xfer          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_s     = out_s_q;

  always_comb begin
    tt_d        = tt_q;
    out_s_d     = out_s_q;
    out_valid_d = out_valid_q;
    if (cfg_we && !busy) tt_d = cfg_tt;
    if (xfer) begin
      out_s_d     = eval_s;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q        <= TT_RESET;
      out_s_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      tt_q        <= tt_d;
      out_s_q     <= out_s_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_gate_lut_unit.sv
// tb_gate_lut_unit: directed vectors for gate_lut_unit, WIDTH = 8.
// Sweep checks run only when GATE_LUT_SWEEP_EN is defined.
module tb_gate_lut_unit;
  import gate_lut_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_we;
  tt_t  cfg_tt;
  logic start;
  logic busy, done, match;
  tt_t  sweep_tt;

  int n_chk = 0;
  int n_err = 0;

  gate_lut_if #(.WIDTH(8)) bus ();

  gate_lut_unit #(.WIDTH(8), .TT_RESET(4'b1101)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_tt   (cfg_tt),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .sweep_tt (sweep_tt),
    .match    (match),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  initial begin
    rst_n         = 1'b0;
    cfg_we        = 1'b0;
    cfg_tt        = '0;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_s", 32'(bus.out_s), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sweep_tt", 32'(sweep_tt), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;
    step();

    // default code a | ~b
    xfer(8'hF0, 8'hCC);
    step();
    chk("ornotb_valid", 32'(bus.out_valid), 1);
    chk("ornotb_s", 32'(bus.out_s), 32'h F3);

    // cfg in same cycle as transfer: old code applies
    cfg_we = 1'b1;
    cfg_tt = TT_XOR;
    xfer(8'hAA, 8'hFF);
    step();
    cfg_we = 1'b0;
    chk("cfg_same_cycle", 32'(bus.out_s), 32'h AA);
    step();
    chk("xor_s", 32'(bus.out_s), 32'h 55);

    // back-to-back
    xfer(8'h0F, 8'h3C);
    step();
    chk("b2b0_s", 32'(bus.out_s), 32'h 33);
    chk("b2b0_valid", 32'(bus.out_valid), 1);
    xfer(8'hFF, 8'h00);
    step();
    chk("b2b1_s", 32'(bus.out_s), 32'h FF);
    chk("b2b1_valid", 32'(bus.out_valid), 1);

    // stall
    bus.out_ready = 1'b0;
    xfer(8'h12, 8'h34);
    #1;
    chk("stall_in_ready", 32'(bus.in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_s", 32'(bus.out_s), 32'h FF);
      chk("stall_valid", 32'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(bus.in_ready), 1);
    step();
    chk("unstall_s", 32'(bus.out_s), 32'h 26);
    chk("unstall_valid", 32'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(bus.out_valid), 0);
    chk("drain_hold_s", 32'(bus.out_s), 32'h 26);

    // more codes, including constant functions
    cfg_we = 1'b1;
    cfg_tt = TT_AND;
    step();
    cfg_tt = TT_NAND;
    xfer(8'hC3, 8'hA5);
    step();
    chk("and_s", 32'(bus.out_s), 32'h 81);
    cfg_tt = 4'b0000;
    step();
    chk("nand_s", 32'(bus.out_s), 32'h 7E);
    cfg_tt = 4'b1111;
    step();
    chk("zero_s", 32'(bus.out_s), 32'h 00);
    cfg_tt = TT_OR;
    step();
    chk("one_s", 32'(bus.out_s), 32'h FF);
    cfg_we = 1'b0;
    xfer(8'h50, 8'h06);
    step();
    chk("or_s", 32'(bus.out_s), 32'h 56);
    bus.in_valid = 1'b0;
    step();

`ifdef GATE_LUT_SWEEP_EN
    cfg_we = 1'b1;
    cfg_tt = TT_NAND;
    step();
    cfg_we = 1'b0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sweep_busy", 32'(busy), 1);
      chk("sweep_done_lo", 32'(done), 0);
      chk("sweep_in_ready", 32'(bus.in_ready), 0);
      cfg_we = 1'b1;
      cfg_tt = TT_AND;
      start  = (i == 1);
      step();
    end
    cfg_we = 1'b0;
    start  = 1'b1;
    chk("sweep_busy_done", 32'(busy), 0);
    chk("sweep_done", 32'(done), 1);
    chk("sweep_tt", 32'(sweep_tt), 32'b0111);
    chk("sweep_match", 32'(match), 1);
    step();
    start = 1'b0;
    chk("sweep_idle_busy", 32'(busy), 0);
    chk("sweep_idle_done", 32'(done), 0);
    chk("sweep_tt_hold", 32'(sweep_tt), 32'b0111);

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_sweep_tt", 32'(sweep_tt), 0);
    chk("mid_match", 32'(match), 0);
    chk("mid_done", 32'(done), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_done", 32'(done), 0);
    end
`else
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("nosweep_busy", 32'(busy), 0);
      chk("nosweep_done", 32'(done), 0);
      chk("nosweep_in_ready", 32'(bus.in_ready), 1);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
`endif

    xfer(8'hF0, 8'hCC);
    step();
    chk("tt_after_rst", 32'(bus.out_s), 32'h F3);
    bus.in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gate_lut_unit.md
# gate_lut_unit

Parametrised, registered two-operand logic unit: evaluates any of the 16 two-input Boolean functions bitwise across WIDTH-bit operands, selected at run time by a 4-bit truth-table code. It generalises the fixed single-bit gate exercises (e.g. s = a | ~b) into a reusable datapath stage with a valid/ready handshake, a one-entry output register and an optional built-in truth-table sweep for self-check. It sits between operand producers and any consumer of bitwise logic results in the lab datapath.

## Interface
- WIDTH, 8, operand/result width in bits (>= 1)
- TT_RESET, 4'b1101, truth-table code loaded at reset (1101 = a | ~b)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- cfg_we  input  1  load cfg_tt into the function register
- cfg_tt  input  4  truth-table code; bit index = {a,b} (bit0 = f(0,0), bit3 = f(1,1))
- in_valid  input  1  operand pair valid
- in_ready  output  1  unit can accept operands
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_s  output  WIDTH  result
- start  input  1  request truth-table sweep (GATE_LUT_SWEEP_EN only)
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse, sweep finished
- sweep_tt  output  4  truth table reproduced by the sweep
- match  output  1  sweep_tt equals active code at sweep end

## Operation
- Function register tt: reset to TT_RESET; loaded from cfg_tt on cfg_we, ignored while busy.
- Evaluation: out bit i = tt[{in_a[i], in_b[i]}], all bits independent.
- Handshake: transfer on in_valid && in_ready; in_ready = (!out_valid || out_ready) && !busy (combinational).
- On transfer, result registered into out_s, out_valid set. out_valid clears on out_ready with no new transfer. Simultaneous drain and accept: out_s replaced, out_valid stays 1.
- out_s and out_valid hold stable while out_valid && !out_ready.
- cfg_we in the same cycle as a transfer: transfer uses the old tt; new tt applies from the next cycle.
- Sweep FSM: IDLE -> S0 -> S1 -> S2 -> S3 -> DONE -> IDLE. start honoured only in IDLE. In Sm internal operands a = all m[1], b = all m[0]; sweep_tt[m] captures bit 0 of the evaluation; all WIDTH bits must agree, disagreement forces match = 0. DONE: done = 1, match computed. Pending output register keeps draining during the sweep.
- Reset values: out_valid 0, out_s 0, busy 0, done 0, sweep_tt 0, match 0, tt = TT_RESET, FSM IDLE.
- Reset mid-sweep: FSM to IDLE immediately, no done pulse, sweep_tt and match cleared.

## Timing
- Data latency: 1 cycle, transfer at edge k -> out_valid at edge k.
- Throughput: one result per cycle while out_ready = 1.
- Sweep: start sampled at edge k; busy = 1 after edges k..k+3 (S0..S3); done = 1 for the cycle after edge k+4; busy = 0 in DONE.
- sweep_tt and match valid from the DONE cycle, held until next start or reset.
- start while busy or in DONE: ignored.

## Configuration
- GATE_LUT_SWEEP_EN defined: sweep FSM, busy, done, sweep_tt, match present as above.
- Not defined: no FSM; busy, done, match tied 0, sweep_tt tied 0, start ignored; in_ready = !out_valid || out_ready; cfg_we always honoured.

## Structure
- Package gate_lut_pkg: tt_t (4-bit code type), sweep state enum, named codes TT_AND = 4'b1000, TT_OR = 4'b1110, TT_XOR = 4'b0110, TT_NAND = 4'b0111, TT_OR_NOTB = 4'b1101.
- Sub-module gate_lut_eval: combinational WIDTH-wide bitwise LUT (tt, a, b -> s), instantiated once, shared by datapath and sweep via operand mux.

## Test plan
- Reset, WIDTH=8, in_a=8'hF0, in_b=8'hCC, out_ready=1 -> out_s = 8'hF3 (a | ~b) one cycle later, out_valid=1.
- cfg_tt=TT_XOR loaded, then in_a=8'hAA, in_b=8'hFF -> out_s = 8'h55; transfer in same cycle as cfg_we still uses previous code.
- out_ready=0 with out_valid=1 -> in_ready=0, out_s stable 3 cycles; out_ready=1 with new in_valid -> back-to-back results, no gap.
- cfg_tt=4'b0111, start pulse -> busy 4 cycles, done pulse, sweep_tt=4'b0111, match=1; start during busy ignored.
- rst_n asserted during S2 -> busy=0, sweep_tt=0, match=0, no done; tt back to 4'b1101.
- Without GATE_LUT_SWEEP_EN: start pulse -> busy, done stay 0; datapath results unchanged.
